// File: rtl/sw_gate_rgb_pwm.sv
// sw_gate_rgb_pwm: debounced switches and mode button, selectable N-input
// logic function, plain LEDs plus two PWM-dimmed RGB status LEDs.
module sw_gate_rgb_pwm #(
  parameter int unsigned N_SW       = 3,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned DUTY       = 32
) (
  input  logic            CLK100MHZ,
  input  logic            BTNC,
  input  logic [N_SW-1:0] SW,
  input  logic            BTNR,
  output logic [N_SW-1:0] LED,
  output logic            LED16_R,
  output logic            LED16_G,
  output logic            LED16_B,
  output logic            LED17_R,
  output logic            LED17_G,
  output logic            LED17_B
);

  // Switches and the mode button share one sync/debounce path; button is the MSB.
  localparam int unsigned N_DEB = N_SW + 1;
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DUTY_L  = PWM_BITS'(DUTY);

  typedef enum logic [1:0] {
    MODE_AND  = 2'd0,
    MODE_NAND = 2'd1,
    MODE_OR   = 2'd2,
    MODE_XOR  = 2'd3
  } mode_e;

  logic [N_DEB-1:0]            raw_c;
  logic [N_DEB-1:0]            s1_q;
  logic [N_DEB-1:0]            s2_q;
  logic [N_DEB-1:0]            deb_q;
  logic [N_DEB-1:0]            deb_d;
  logic [N_DEB-1:0][CNT_W-1:0] cnt_q;
  logic [N_DEB-1:0][CNT_W-1:0] cnt_d;

  logic [N_SW-1:0]     deb_sw_c;
  logic                deb_btn_c;
  logic                btn_prev_q;
  logic                btn_rise_c;
  mode_e               mode_q;
  logic [PWM_BITS-1:0] pcnt_q;
  logic                on_c;
  logic                f_c;
  logic [2:0]          rgb16_c;
  logic [2:0]          rgb17_c;

  logic [N_SW-1:0] led_q;
  logic [2:0]      rgb16_q;
  logic [2:0]      rgb17_q;

  assign raw_c = {BTNR, SW};

  // Two-flop synchroniser for every asynchronous pin.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw_c;
      s2_q <= s1_q;
    end
  end

  // Per-bit debounce: a bit flips after DEB_CYCLES consecutive differing samples.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < int'(N_DEB); i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_sw_c   = deb_q[N_SW-1:0];
  assign deb_btn_c  = deb_q[N_SW];
  assign btn_rise_c = deb_btn_c & ~btn_prev_q;

  // Mode FSM: one step per debounced button press, wrapping XOR -> AND.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      btn_prev_q <= 1'b0;
      mode_q     <= MODE_AND;
    end else begin
      btn_prev_q <= deb_btn_c;
      if (btn_rise_c) begin
        case (mode_q)
          MODE_AND:  mode_q <= MODE_NAND;
          MODE_NAND: mode_q <= MODE_OR;
          MODE_OR:   mode_q <= MODE_XOR;
          default:   mode_q <= MODE_AND;
        endcase
      end
    end
  end

  // Free-running PWM counter.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PWM_BITS'(1);
    end
  end

  assign on_c = (pcnt_q < DUTY_L);

  // Selected logic function and RGB colour codes ({R,G,B}), gated by PWM.
  always_comb begin
    f_c     = 1'b0;
    rgb16_c = 3'b000;
    case (mode_q)
      MODE_AND: begin
        f_c     = &deb_sw_c;
        rgb16_c = 3'b100;
      end
      MODE_NAND: begin
        f_c     = ~&deb_sw_c;
        rgb16_c = 3'b010;
      end
      MODE_OR: begin
        f_c     = |deb_sw_c;
        rgb16_c = 3'b001;
      end
      default: begin
        f_c     = ^deb_sw_c;
        rgb16_c = 3'b101;
      end
    endcase
    rgb17_c = f_c ? 3'b001 : 3'b100;
    rgb16_c = rgb16_c & {3{on_c}};
    rgb17_c = rgb17_c & {3{on_c}};
  end

  // Registered outputs.
  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      led_q   <= '0;
      rgb16_q <= '0;
      rgb17_q <= '0;
    end else begin
      led_q   <= deb_sw_c;
      rgb16_q <= rgb16_c;
      rgb17_q <= rgb17_c;
    end
  end

  assign LED     = led_q;
  assign LED16_R = rgb16_q[2];
  assign LED16_G = rgb16_q[1];
  assign LED16_B = rgb16_q[0];
  assign LED17_R = rgb17_q[2];
  assign LED17_G = rgb17_q[1];
  assign LED17_B = rgb17_q[0];

endmodule

// File: tb/tb_sw_gate_rgb_pwm.sv
// Testbench for sw_gate_rgb_pwm: directed scenarios plus random stimulus,
// checked against a cycle-history reference model.
module tb_sw_gate_rgb_pwm;

  localparam int NSW  = 3;
  localparam int DEB  = 4;
  localparam int PB   = 4;
  localparam int DT   = 4;
  localparam int PER  = 16;

  logic       clk = 1'b0;
  logic       btnc = 1'b0;
  logic [2:0] sw = 3'b000;
  logic       btnr = 1'b0;

  logic [2:0] led, led0;
  logic r16, g16, b16, r17, g17, b17;
  logic q16r, q16g, q16b, q17r, q17g, q17b;

  int checks = 0;
  int errors = 0;

  sw_gate_rgb_pwm #(.N_SW(NSW), .DEB_CYCLES(DEB), .PWM_BITS(PB), .DUTY(DT)) u_dut (
    .CLK100MHZ(clk), .BTNC(btnc), .SW(sw), .BTNR(btnr), .LED(led),
    .LED16_R(r16), .LED16_G(g16), .LED16_B(b16),
    .LED17_R(r17), .LED17_G(g17), .LED17_B(b17)
  );

  sw_gate_rgb_pwm #(.N_SW(NSW), .DEB_CYCLES(DEB), .PWM_BITS(PB), .DUTY(0)) u_dut0 (
    .CLK100MHZ(clk), .BTNC(btnc), .SW(sw), .BTNR(btnr), .LED(led0),
    .LED16_R(q16r), .LED16_G(q16g), .LED16_B(q16b),
    .LED17_R(q17r), .LED17_G(q17g), .LED17_B(q17b)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {led, r16, g16, b16, r17, g17, b17};
  endfunction

  function automatic logic [8:0] obs0();
    return {led0, q16r, q16g, q16b, q17r, q17g, q17b};
  endfunction

  // Reference model: pin history window, mode as integer, PWM phase from cycle count.
  logic [3:0] hist [0:DEB+1];
  logic [3:0] m_deb;
  logic       m_btn_prev;
  int         m_mode;
  int         m_cycles;
  logic [8:0] exp_pack;
  logic [8:0] exp0_pack;

  always @(posedge clk or posedge btnc) begin
    if (btnc) begin
      for (int j = 0; j <= DEB + 1; j++) hist[j] = 4'b0;
      m_deb = 4'b0; m_btn_prev = 1'b0; m_mode = 0; m_cycles = 0;
      exp_pack = 9'b0; exp0_pack = 9'b0;
    end else begin
      logic on, f, same;
      logic [2:0] c16, c17;
      on = ((m_cycles % PER) < DT);
      case (m_mode)
        0: begin f = &m_deb[2:0];  c16 = 3'b100; end
        1: begin f = ~&m_deb[2:0]; c16 = 3'b010; end
        2: begin f = |m_deb[2:0];  c16 = 3'b001; end
        default: begin f = ^m_deb[2:0]; c16 = 3'b101; end
      endcase
      c17 = f ? 3'b001 : 3'b100;
      if (!on) begin c16 = 3'b000; c17 = 3'b000; end
      exp_pack  = {m_deb[2:0], c16, c17};
      exp0_pack = {m_deb[2:0], 6'b0};
      if (m_deb[3] && !m_btn_prev) m_mode = (m_mode + 1) % 4;
      m_btn_prev = m_deb[3];
      for (int j = DEB + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = {btnr, sw};
      // sync output lags the pin by two edges; a bit flips once DEB successive
      // sync samples all disagree with the debounced value
      for (int b = 0; b < 4; b++) begin
        same = 1'b1;
        for (int j = 2; j <= DEB + 1; j++)
          if (hist[j][b] !== hist[2][b]) same = 1'b0;
        if (same && hist[2][b] !== m_deb[b]) m_deb[b] = hist[2][b];
      end
      m_cycles++;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    btnc = 1'b0;
    step(3);
    sw = 3'b111;
    step(4);
    sw = 3'b001;
    step(2);
    #2 btnc = 1'b1;
    #1;
    checks++;
    if (obs() !== 9'b0 || obs0() !== 9'b0) begin
      errors++;
      $display("FAIL reset_async got %b/%b exp 0", obs(), obs0());
    end
    step(2);
    checks++;
    if (obs() !== 9'b0) begin
      errors++;
      $display("FAIL reset_held got %b exp 0", obs());
    end
    btnc = 1'b0;
    step(1);
    checks++;
    if (obs() !== 9'b000_100_100) begin
      errors++;
      $display("FAIL reset_first_cycle got %b exp 000100100", obs());
    end
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if (obs() !== exp_pack) begin
        errors++;
        $display("FAIL reset_model cycle %0d got %b exp %b", i, obs(), exp_pack);
      end
    end
    checks++;
    if (led !== 3'b001) begin
      errors++;
      $display("FAIL reset_led_after got %b exp 001", led);
    end
    sw = 3'b000;
    step(10);
  endtask

  task automatic test_debounce();
    sw[0] = 1'b1;
    step(3);
    sw[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      checks++;
      if (led[0] !== 1'b0) begin
        errors++;
        $display("FAIL deb_glitch cycle %0d got %b exp 0", i, led[0]);
      end
    end
    sw[0] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step(1);
      checks++;
      if (led[0] !== (n >= 7)) begin
        errors++;
        $display("FAIL deb_latency cycle %0d got %b exp %b", n, led[0], (n >= 7));
      end
    end
    sw = 3'b000;
    step(10);
  endtask

  task automatic press(input int hold);
    btnr = 1'b1;
    step(hold);
    btnr = 1'b0;
    step(12);
  endtask

  task automatic test_mode();
    logic [2:0] seen;
    logic [2:0] exp_col [0:3];
    exp_col[0] = 3'b010; exp_col[1] = 3'b001; exp_col[2] = 3'b101; exp_col[3] = 3'b100;
    for (int p = 0; p < 4; p++) begin
      press(p == 0 ? 20 : 8);
      seen = 3'b000;
      for (int i = 0; i < PER; i++) begin
        step(1);
        seen = seen | {r16, g16, b16};
      end
      checks++;
      if (seen !== exp_col[p]) begin
        errors++;
        $display("FAIL mode_colour press %0d got %b exp %b", p, seen, exp_col[p]);
      end
    end
  endtask

  task automatic test_function();
    logic [2:0] seen;
    logic [2:0] exp_col [0:4];
    exp_col[0] = 3'b100; exp_col[1] = 3'b001; exp_col[2] = 3'b001;
    exp_col[3] = 3'b100; exp_col[4] = 3'b001;
    sw = 3'b011;
    step(10);
    for (int p = 0; p < 5; p++) begin
      if (p >= 1 && p <= 3) press(8);
      if (p == 4) begin
        sw = 3'b111;
        step(10);
      end
      seen = 3'b000;
      for (int i = 0; i < PER; i++) begin
        step(1);
        seen = seen | {r17, g17, b17};
      end
      checks++;
      if (seen !== exp_col[p]) begin
        errors++;
        $display("FAIL func_colour case %0d got %b exp %b", p, seen, exp_col[p]);
      end
    end
    press(8);
  endtask

  task automatic test_pwm();
    int hi, hi0;
    hi = 0; hi0 = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      step(1);
      if (r17 | b17) hi++;
      if (q16r | q16g | q16b | q17r | q17g | q17b) hi0++;
      checks++;
      if (obs() !== exp_pack || obs0() !== exp0_pack) begin
        errors++;
        $display("FAIL pwm_phase cycle %0d got %b/%b exp %b/%b", i, obs(), obs0(), exp_pack, exp0_pack);
      end
    end
    checks++;
    if (hi !== 2 * DT) begin
      errors++;
      $display("FAIL pwm_on_count got %0d exp %0d", hi, 2 * DT);
    end
    checks++;
    if (hi0 !== 0 || led0 !== led) begin
      errors++;
      $display("FAIL pwm_duty0 got hi=%0d led=%b exp hi=0 led=%b", hi0, led0, led);
    end
  endtask

  task automatic test_simultaneous();
    int t1, t2;
    sw = 3'b001;
    step(10);
    t1 = -1; t2 = -1;
    sw = 3'b111;
    for (int n = 1; n <= 12; n++) begin
      step(1);
      if (t1 < 0 && led[1] === 1'b1) t1 = n;
      if (t2 < 0 && led[2] === 1'b1) t2 = n;
    end
    checks++;
    if (t1 !== 7 || t2 !== 7) begin
      errors++;
      $display("FAIL simul_flip got t1=%0d t2=%0d exp 7 7", t1, t2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) sw = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) btnr = ~btnr;
      step(1);
      checks++;
      if (obs() !== exp_pack || obs0() !== exp0_pack) begin
        errors++;
        $display("FAIL random cycle %0d got %b/%b exp %b/%b", i, obs(), obs0(), exp_pack, exp0_pack);
      end
    end
    btnr = 1'b0;
  endtask

  initial begin
    #1 btnc = 1'b1;
    test_reset();
    test_debounce();
    test_mode();
    test_function();
    test_pwm();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
